stepper_seq_ctrl: RTL and testbench

//  Parametrised 4-coil stepper sequencer and successor to the fixed half-step state machine.

---
 rtl/stepper_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_stepper_seq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_seq_ctrl.sv
// stepper_seq_ctrl
//   Four-coil unipolar stepper sequencer. Takes move commands (direction,
//   mode, step count, step period) over a valid/ready handshake. It times the
//   steps internally and drives wave, two-phase or half-step coil patterns.
//   It also tracks a signed absolute position in half-step units.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready    command handshake; ready only while idle
//   cmd_dir            1 = forward (index +), 0 = reverse
//   cmd_mode           00/11 half-step, 01 wave, 10 two-phase
//   cmd_steps          steps to execute (0 = no motion, done still pulses)
//   cmd_period         clocks per step (0 behaves as 1)
//   abort              ends a running move at the next edge, no step taken
//   hold_en            keep the last pattern energised while idle
//   coil_out           registered coil drive {A,B,C,D}
//   busy               high while a move runs
//   done               one-cycle pulse at the end of a move
//   aborted            the last move was ended by abort (held until next accept)
//   position           signed position, wraps at POS_W bits
module stepper_seq_ctrl #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 20,
    parameter int POS_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             hold_en,
    output logic [3:0]       coil_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] position
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   per_q, per_d;
    logic               dir_q, dir_d;
    logic               full_q, full_d;     // full-step modes move two table entries
    logic [3:0]         coil_q, coil_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic               accept;
    logic [2:0]         step_amt;
    logic [POS_W-1:0]   pos_amt;

    // Even entries energise one coil, odd entries two adjacent coils.
    function automatic logic [3:0] pattern(input logic [2:0] i);
        case (i)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
    endfunction

    always_comb begin
        accept    = cmd_valid && (state_q == ST_IDLE);
        step_amt  = full_q ? 3'd2 : 3'd1;
        pos_amt   = full_q ? POS_W'(2) : POS_W'(1);

        state_d   = state_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        rem_d     = rem_q;
        div_d     = div_q;
        per_d     = per_q;
        dir_d     = dir_q;
        full_d    = full_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dir_d     = cmd_dir;
                    full_d    = (cmd_mode == 2'b01) || (cmd_mode == 2'b10);
                    rem_d     = cmd_steps;
                    per_d     = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
                    div_d     = per_d;
                    aborted_d = 1'b0;
                    // Snap onto the even (wave) or odd (two-phase) entries;
                    // this is alignment only and does not count as a step.
                    if (cmd_mode == 2'b01)
                        idx_d = {idx_q[2:1], 1'b0};
                    else if (cmd_mode == 2'b10)
                        idx_d = {idx_q[2:1], 1'b1};
                    if (cmd_steps == '0)
                        done_d = 1'b1;
                    else
                        state_d = ST_RUN;
                end
            end
            default: begin
                // Abort takes priority over a step landing on the same edge.
                if (abort) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (div_q == DIV_W'(1)) begin
                    idx_d = dir_q ? (idx_q + step_amt) : (idx_q - step_amt);
                    pos_d = dir_q ? (pos_q + pos_amt) : (pos_q - pos_amt);
                    rem_d = rem_q - CNT_W'(1);
                    div_d = per_q;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
        endcase

        // Built from the current index, so the pattern trails an index change by one clock.
        coil_d = ((state_q == ST_RUN) || hold_en) ? pattern(idx_q) : 4'b0000;
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pos_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            per_q     <= '0;
            dir_q     <= 1'b0;
            full_q    <= 1'b0;
            coil_q    <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pos_q     <= pos_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            per_q     <= per_d;
            dir_q     <= dir_d;
            full_q    <= full_d;
            coil_q    <= coil_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign coil_out  = coil_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Bench for stepper_seq_ctrl: a default-size instance plus a POS_W=4 instance
// sharing the same inputs for position wrap. Each move pushes the expected
// per-cycle coil/done/busy values into a queue, which is drained as the DUT runs.
module tb_stepper_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_dir, abort, hold_en;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_steps;
    logic [19:0] cmd_period;
    logic        cmd_ready, busy, done, aborted;
    logic [3:0]  coil_out;
    logic [23:0] position;
    logic        cmd_ready4, busy4, done4, aborted4;
    logic [3:0]  coil_out4;
    logic [3:0]  position4;

    stepper_seq_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_mode(cmd_mode), .cmd_steps(cmd_steps),
        .cmd_period(cmd_period), .abort(abort), .hold_en(hold_en),
        .coil_out(coil_out), .busy(busy), .done(done), .aborted(aborted),
        .position(position)
    );

    stepper_seq_ctrl #(.POS_W(4)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_dir(cmd_dir), .cmd_mode(cmd_mode), .cmd_steps(cmd_steps),
        .cmd_period(cmd_period), .abort(abort), .hold_en(hold_en),
        .coil_out(coil_out4), .busy(busy4), .done(done4), .aborted(aborted4),
        .position(position4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] coil;
        logic       done;
        logic       busy;
        logic       ready;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int         n_vec = 0;
    int         n_err = 0;
    int         m_idx = 0;
    int         m_pos = 0;

    function automatic int wrap8(input int x);
        return ((x % 8) + 8) % 8;
    endfunction

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_mode = 2'b00;
        cmd_steps = '0; cmd_period = '0; abort = 1'b0; hold_en = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (coil_out !== 4'b0000) begin n_err++; $display("FAIL reset_coil got %b exp 0000", coil_out); end
        n_vec++; if ({busy, done, aborted} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {busy, done, aborted}); end
        n_vec++; if (position !== 24'd0) begin n_err++; $display("FAIL reset_pos got %0d exp 0", position); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
        n_vec++; if (coil_out !== 4'b0000) begin n_err++; $display("FAIL post_reset_coil got %b exp 0000", coil_out); end
        m_idx = 0; m_pos = 0;
    endtask

    // Generic move; abort_step > 0 raises abort so it lands on that step's edge.
    task automatic run_move(input bit dir, input logic [1:0] mode, input int steps,
                            input int period, input bit hold, input int abort_step,
                            input string name);
        int pe, delta, sgn, cend, taken, idx_pre, idx0, c;
        exp_t e;
        logic [23:0] p24;
        logic [3:0]  p4;
        pe      = (period == 0) ? 1 : period;
        delta   = (mode == 2'b01 || mode == 2'b10) ? 2 : 1;
        sgn     = dir ? 1 : -1;
        idx_pre = m_idx;
        idx0    = m_idx;
        if (mode == 2'b01) idx0 = idx0 & 6;
        if (mode == 2'b10) idx0 = idx0 | 1;
        if (abort_step > 0) begin cend = abort_step * pe; taken = abort_step - 1; end
        else                begin cend = steps * pe;      taken = steps;          end
        e.ready = 1'b0;
        e.coil = hold ? tbl[idx_pre] : 4'b0000; e.done = (cend == 0); e.busy = (cend > 0);
        sb.push_back(e);
        for (int k = 1; k <= cend; k++) begin
            e.coil = tbl[wrap8(idx0 + sgn * delta * ((k - 1) / pe))];
            e.done = (k == cend);
            e.busy = (k < cend);
            sb.push_back(e);
        end
        m_idx = wrap8(idx0 + sgn * delta * taken);
        m_pos = m_pos + sgn * delta * taken;
        e.coil = hold ? tbl[m_idx] : 4'b0000; e.done = 1'b0; e.busy = 1'b0;
        sb.push_back(e);
        p24 = m_pos[23:0];
        p4  = m_pos[3:0];

        @(negedge clk);
        cmd_dir = dir; cmd_mode = mode; cmd_steps = 16'(steps); cmd_period = 20'(period);
        hold_en = hold; cmd_valid = 1'b1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s ready got %b exp 1", name, cmd_ready); end
        c = -1;
        while (sb.size() > 0) begin
            @(negedge clk);
            c++;
            e = sb.pop_front();
            n_vec++; if (coil_out !== e.coil) begin n_err++; $display("FAIL %s coil c=%0d got %b exp %b", name, c, coil_out, e.coil); end
            n_vec++; if (done !== e.done) begin n_err++; $display("FAIL %s done c=%0d got %b exp %b", name, c, done, e.done); end
            n_vec++; if (busy !== e.busy) begin n_err++; $display("FAIL %s busy c=%0d got %b exp %b", name, c, busy, e.busy); end
            if (c == cend) begin
                n_vec++; if (position !== p24) begin n_err++; $display("FAIL %s position got %0d exp %0d", name, $signed(position), $signed(p24)); end
                n_vec++; if (position4 !== p4) begin n_err++; $display("FAIL %s position4 got %b exp %b", name, position4, p4); end
                n_vec++; if (aborted !== (abort_step > 0)) begin n_err++; $display("FAIL %s aborted got %b exp %b", name, aborted, abort_step > 0); end
            end
            if (c == 0) cmd_valid = 1'b0;
            abort = (abort_step > 0) && (c == cend - 1);
        end
        abort = 1'b0;
    endtask

    task automatic test_half_fwd();
        run_move(1'b1, 2'b00, 8, 4, 1'b1, 0, "half_fwd");
    endtask

    task automatic test_wave_rev();
        run_move(1'b1, 2'b00, 3, 2, 1'b1, 0, "pre_wave");     // idx -> 3
        run_move(1'b0, 2'b01, 3, 2, 1'b1, 0, "wave_rev");
    endtask

    task automatic test_two_phase();
        run_move(1'b1, 2'b10, 4, 0, 1'b1, 0, "two_phase");
    endtask

    task automatic test_abort();
        run_move(1'b1, 2'b00, 100, 10, 1'b1, 3, "abort");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL idle_abort done got %b exp 0", done); end
        n_vec++; if (aborted !== 1'b1) begin n_err++; $display("FAIL idle_abort aborted got %b exp 1", aborted); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_abort busy got %b exp 0", busy); end
    endtask

    task automatic test_zero_steps();
        run_move(1'b1, 2'b00, 0, 5, 1'b1, 0, "zero_steps");
    endtask

    // Command A runs while command B is held valid; B is taken the cycle done rises.
    task automatic test_back_to_back();
        exp_t e;
        logic [23:0] p24;
        for (int k = 0; k <= 9; k++) begin
            e.coil  = 4'b0000;
            e.ready = (k == 6) || (k == 9);
            e.done  = (k == 6) || (k == 9);
            e.busy  = !((k == 6) || (k == 9));
            sb.push_back(e);
        end
        m_idx = wrap8(m_idx + 1);
        m_pos = m_pos + 1;
        p24 = m_pos[23:0];
        @(negedge clk);
        hold_en = 1'b1; cmd_dir = 1'b1; cmd_mode = 2'b00; cmd_steps = 16'd2; cmd_period = 20'd3;
        cmd_valid = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_vec++; if (cmd_ready !== e.ready) begin n_err++; $display("FAIL b2b ready c=%0d got %b exp %b", c, cmd_ready, e.ready); end
            n_vec++; if (done !== e.done) begin n_err++; $display("FAIL b2b done c=%0d got %b exp %b", c, done, e.done); end
            n_vec++; if (busy !== e.busy) begin n_err++; $display("FAIL b2b busy c=%0d got %b exp %b", c, busy, e.busy); end
            if (c == 0) begin cmd_dir = 1'b0; cmd_steps = 16'd1; cmd_period = 20'd2; end
            if (c == 7) cmd_valid = 1'b0;
            if (c == 9) begin
                n_vec++; if (position !== p24) begin n_err++; $display("FAIL b2b position got %0d exp %0d", $signed(position), $signed(p24)); end
            end
        end
    endtask

    task automatic test_hold_reset();
        run_move(1'b1, 2'b00, 2, 1, 1'b0, 0, "no_hold");
        @(negedge clk);
        n_vec++; if (coil_out !== 4'b0000) begin n_err++; $display("FAIL no_hold idle coil got %b exp 0000", coil_out); end
        cmd_dir = 1'b1; cmd_mode = 2'b00; cmd_steps = 16'd50; cmd_period = 20'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_move busy got %b exp 1", busy); end
        rst = 1'b1;
        #1;
        n_vec++; if (coil_out !== 4'b0000) begin n_err++; $display("FAIL rst_mid coil got %b exp 0000", coil_out); end
        n_vec++; if ({busy, done, aborted} !== 3'b000) begin n_err++; $display("FAIL rst_mid flags got %b exp 000", {busy, done, aborted}); end
        n_vec++; if (position !== 24'd0) begin n_err++; $display("FAIL rst_mid position got %0d exp 0", position); end
        n_vec++; if (position4 !== 4'd0) begin n_err++; $display("FAIL rst_mid position4 got %0d exp 0", position4); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL post_rst done c=%0d got %b exp 0", c, done); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst busy c=%0d got %b exp 0", c, busy); end
        end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_rst ready got %b exp 1", cmd_ready); end
        m_idx = 0; m_pos = 0;
        run_move(1'b1, 2'b00, 1, 1, 1'b1, 0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_half_fwd();
        test_wave_rev();
        test_two_phase();
        test_abort();
        test_zero_steps();
        test_back_to_back();
        test_hold_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
